// File: rtl/mem_to_banks_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_to_banks_pkg
// Brief    : Address alignment and lane-index helpers for mem_to_banks_masked.
// Revision : 1.0 - initial release
// ============================================================================
package mem_to_banks_pkg;

    // Clears the byte-offset bits below one full data word.
    function automatic logic [63:0] align_addr(input logic [63:0] addr,
                                               input int unsigned bytes_per_word);
        return addr & ~(64'(bytes_per_word) - 64'd1);
    endfunction

    function automatic int unsigned lane_idx_width(input int unsigned num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
// Module   : fifo_v3
// Brief    : Circular-buffer FIFO with optional fall-through (empty bypass).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [2**c_ptr_w];
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w:0]      r_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bypass;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign full_o   = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign empty_o  = (r_count == '0) && !(FALL_THROUGH && push_i);
    assign data_o   = (FALL_THROUGH && (r_count == '0)) ? data_i : r_mem[r_rd_ptr];
    assign w_push   = push_i && !full_o;
    assign w_pop    = pop_i && !empty_o;
    // Push and pop on an empty fall-through FIFO pass straight through.
    assign w_bypass = w_push && w_pop && (r_count == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (!w_bypass) begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + (c_ptr_w + 1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (c_ptr_w + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !w_bypass) r_mem[r_wr_ptr] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/mem_bank_lane.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank_lane
// Brief    : One bank lane: gated fall-through request FIFO plus response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bank_lane import mem_to_banks_pkg::*; #(
    parameter int unsigned REQ_WIDTH = 8,
    parameter int unsigned RSP_WIDTH = 8,
    parameter int unsigned REQ_DEPTH = 1,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 active_i,
    input  logic                 push_i,
    input  logic [REQ_WIDTH-1:0] req_data_i,
    output logic                 ready_o,
    output logic                 bank_req_o,
    input  logic                 bank_gnt_i,
    output logic [REQ_WIDTH-1:0] bank_data_o,
    input  logic                 bank_rvalid_i,
    input  logic [RSP_WIDTH-1:0] bank_rsp_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_pop_i,
    output logic [RSP_WIDTH-1:0] rsp_data_o
);
    logic w_req_ready;
    logic w_rsp_full;
    logic w_rsp_empty;

    stream_fifo #(
        .FALL_THROUGH(1'b1),
        .DATA_WIDTH  (REQ_WIDTH),
        .DEPTH       (REQ_DEPTH)
    ) i_req_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .valid_i(push_i & active_i),
        .ready_o(w_req_ready),
        .data_i (req_data_i),
        .valid_o(bank_req_o),
        .ready_i(bank_gnt_i),
        .data_o (bank_data_o)
    );

    // An inactive lane never blocks the grant.
    assign ready_o = w_req_ready | ~active_i;

    fifo_v3 #(
        .FALL_THROUGH(1'b0),
        .DATA_WIDTH  (RSP_WIDTH),
        .DEPTH       (RSP_DEPTH)
    ) i_rsp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .full_o (w_rsp_full),
        .empty_o(w_rsp_empty),
        .data_i (bank_rsp_i),
        .push_i (bank_rvalid_i & ~w_rsp_full),
        .data_o (rsp_data_o),
        .pop_i  (rsp_pop_i)
    );

    assign rsp_valid_o = ~w_rsp_empty;

endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_fifo
// Brief    : Valid/ready handshake wrapper around fifo_v3.
// Revision : 1.0 - initial release
// ============================================================================
module stream_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic w_full;
    logic w_empty;

    fifo_v3 #(
        .FALL_THROUGH(FALL_THROUGH),
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH)
    ) i_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .full_o (w_full),
        .empty_o(w_empty),
        .data_i (data_i),
        .push_i (valid_i),
        .data_o (data_o),
        .pop_i  (ready_i)
    );

    assign ready_o = ~w_full;
    assign valid_o = ~w_empty;

endmodule
`default_nettype wire

// File: rtl/mem_to_banks_masked.sv
`default_nettype none
// ============================================================================
// Module   : mem_to_banks_masked
// Brief    : Splits wide memory requests across banks, skipping strobe-idle
//            lanes; COMMON_CELLS_MTB_READ_MASK_EN also masks reads by strobe.
// Revision : 1.0 - initial release
// ============================================================================
module mem_to_banks_masked import mem_to_banks_pkg::*; #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned NumBanks   = 2,
    parameter int unsigned MaxTrans   = 2,
    parameter int unsigned FifoDepth  = 1,
    parameter int unsigned WUserWidth = 1,
    parameter int unsigned RUserWidth = 1
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            req_i,
    output logic                                            gnt_o,
    input  logic [AddrWidth-1:0]                            addr_i,
    input  logic [DataWidth-1:0]                            wdata_i,
    input  logic [DataWidth/8-1:0]                          strb_i,
    input  logic [WUserWidth-1:0]                           wuser_i,
    input  logic                                            we_i,
    output logic                                            rvalid_o,
    output logic [DataWidth-1:0]                            rdata_o,
    output logic [NumBanks*RUserWidth-1:0]                  ruser_o,
    output logic [NumBanks-1:0]                             bank_req_o,
    input  logic [NumBanks-1:0]                             bank_gnt_i,
    output logic [NumBanks-1:0][AddrWidth-1:0]              bank_addr_o,
    output logic [NumBanks-1:0][DataWidth/NumBanks-1:0]     bank_wdata_o,
    output logic [NumBanks-1:0][DataWidth/NumBanks/8-1:0]   bank_strb_o,
    output logic [NumBanks-1:0][WUserWidth-1:0]             bank_wuser_o,
    output logic [NumBanks-1:0]                             bank_we_o,
    input  logic [NumBanks-1:0]                             bank_rvalid_i,
    input  logic [NumBanks-1:0][DataWidth/NumBanks-1:0]     bank_rdata_i,
    input  logic [NumBanks-1:0][RUserWidth-1:0]             bank_ruser_i,
    output logic [$clog2(MaxTrans+1)-1:0]                   outstanding_o,
    output logic                                            busy_o
);
    localparam int unsigned c_bank_dw = DataWidth / NumBanks;
    localparam int unsigned c_bank_sw = c_bank_dw / 8;
    localparam int unsigned c_out_w   = $clog2(MaxTrans + 1);
    localparam int unsigned c_idx_w   = lane_idx_width(NumBanks);

    typedef struct packed {
        logic [AddrWidth-1:0]  addr;
        logic [c_bank_dw-1:0]  wdata;
        logic [c_bank_sw-1:0]  strb;
        logic [WUserWidth-1:0] wuser;
        logic                  we;
    } bank_req_t;

    typedef struct packed {
        logic [c_bank_dw-1:0]  rdata;
        logic [RUserWidth-1:0] ruser;
    } bank_rsp_t;

    logic [AddrWidth-1:0]       w_aligned;
    logic [NumBanks-1:0]        w_active;
    logic [NumBanks-1:0]        w_ready;
    logic [NumBanks-1:0]        w_rsp_valid;
    logic [NumBanks-1:0]        w_head_mask;
    logic                       w_mask_full;
    logic                       w_mask_empty;
    logic                       w_accept;
    logic                       w_rvalid;
    logic [c_out_w-1:0]         r_outstanding;
    bank_req_t [NumBanks-1:0]   w_bank_in;
    bank_req_t [NumBanks-1:0]   w_bank_out;
    bank_rsp_t [NumBanks-1:0]   w_rsp_in;
    bank_rsp_t [NumBanks-1:0]   w_rsp_out;

    assign w_aligned = AddrWidth'(align_addr(64'(addr_i), DataWidth / 8));
    assign gnt_o     = (&w_ready) & ~w_mask_full & (r_outstanding < c_out_w'(MaxTrans));
    assign w_accept  = req_i & gnt_o;
    // Lanes outside the head mask are treated as already answered.
    assign w_rvalid  = ~w_mask_empty & (&(w_rsp_valid | ~w_head_mask));
    assign rvalid_o  = w_rvalid;

    for (genvar i = 0; i < NumBanks; i++) begin : g_lanes
        localparam logic [c_idx_w-1:0] c_lane = c_idx_w'(i);
        logic w_strb_nz;

        assign w_strb_nz = |strb_i[i*c_bank_sw +: c_bank_sw];
`ifdef COMMON_CELLS_MTB_READ_MASK_EN
        assign w_active[i] = w_strb_nz;
`else
        assign w_active[i] = w_strb_nz | ~we_i;
`endif

        assign w_bank_in[i] = '{
            addr:  w_aligned + AddrWidth'(c_lane) * AddrWidth'(c_bank_sw),
            wdata: wdata_i[i*c_bank_dw +: c_bank_dw],
            strb:  strb_i[i*c_bank_sw +: c_bank_sw],
            wuser: wuser_i,
            we:    we_i
        };
        assign w_rsp_in[i] = '{rdata: bank_rdata_i[i], ruser: bank_ruser_i[i]};

        mem_bank_lane #(
            .REQ_WIDTH($bits(bank_req_t)),
            .RSP_WIDTH($bits(bank_rsp_t)),
            .REQ_DEPTH(FifoDepth),
            .RSP_DEPTH(MaxTrans)
        ) i_lane (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .active_i     (w_active[i]),
            .push_i       (w_accept),
            .req_data_i   (w_bank_in[i]),
            .ready_o      (w_ready[i]),
            .bank_req_o   (bank_req_o[i]),
            .bank_gnt_i   (bank_gnt_i[i]),
            .bank_data_o  (w_bank_out[i]),
            .bank_rvalid_i(bank_rvalid_i[i]),
            .bank_rsp_i   (w_rsp_in[i]),
            .rsp_valid_o  (w_rsp_valid[i]),
            .rsp_pop_i    (w_rvalid & w_head_mask[i]),
            .rsp_data_o   (w_rsp_out[i])
        );

        assign bank_addr_o[i]  = w_bank_out[i].addr;
        assign bank_wdata_o[i] = w_bank_out[i].wdata;
        assign bank_strb_o[i]  = w_bank_out[i].strb;
        assign bank_wuser_o[i] = w_bank_out[i].wuser;
        assign bank_we_o[i]    = w_bank_out[i].we;

        assign rdata_o[i*c_bank_dw +: c_bank_dw]   = w_head_mask[i] ? w_rsp_out[i].rdata : '0;
        assign ruser_o[i*RUserWidth +: RUserWidth] = w_head_mask[i] ? w_rsp_out[i].ruser : '0;
    end

    fifo_v3 #(
        .FALL_THROUGH(1'b0),
        .DATA_WIDTH  (NumBanks),
        .DEPTH       (MaxTrans)
    ) i_mask_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .full_o (w_mask_full),
        .empty_o(w_mask_empty),
        .data_i (w_active),
        .push_i (w_accept),
        .data_o (w_head_mask),
        .pop_i  (w_rvalid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else if (w_accept && !w_rvalid) begin
            r_outstanding <= r_outstanding + c_out_w'(1);
        end else if (!w_accept && w_rvalid) begin
            r_outstanding <= r_outstanding - c_out_w'(1);
        end
    end

    assign outstanding_o = r_outstanding;
    assign busy_o        = (r_outstanding != '0);

endmodule
`default_nettype wire

// File: tb/tb_mem_to_banks_masked.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_to_banks_masked
// Brief    : Directed self-checking bench for mem_to_banks_masked (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_to_banks_masked;
    logic             clk;
    logic             rst_n;
    logic             req, gnt, we, rvalid, busy;
    logic [31:0]      addr;
    logic [63:0]      wdata, rdata;
    logic [7:0]       strb;
    logic [0:0]       wuser;
    logic [1:0]       ruser;
    logic [1:0]       bank_req, bank_gnt, bank_we, bank_rvalid;
    logic [1:0][31:0] bank_addr, bank_wdata, bank_rdata;
    logic [1:0][3:0]  bank_strb;
    logic [1:0][0:0]  bank_wuser, bank_ruser;
    logic [1:0]       outstanding;

    int n_cmp = 0;
    int n_err = 0;

    mem_to_banks_masked dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .gnt_o        (gnt),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .strb_i       (strb),
        .wuser_i      (wuser),
        .we_i         (we),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .ruser_o      (ruser),
        .bank_req_o   (bank_req),
        .bank_gnt_i   (bank_gnt),
        .bank_addr_o  (bank_addr),
        .bank_wdata_o (bank_wdata),
        .bank_strb_o  (bank_strb),
        .bank_wuser_o (bank_wuser),
        .bank_we_o    (bank_we),
        .bank_rvalid_i(bank_rvalid),
        .bank_rdata_i (bank_rdata),
        .bank_ruser_i (bank_ruser),
        .outstanding_o(outstanding),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; strb = '0;
        wuser = '0; bank_gnt = '0; bank_rvalid = '0; bank_rdata = '0; bank_ruser = '0;
        #3;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bank_req", bank_req, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("rst_gnt", gnt, 1);

        // Test 1: unaligned read, both lanes active
        req = 1'b1; we = 1'b0; addr = 32'h13; strb = 8'h00;
        #1;
        chk("t1_bank_req", bank_req, 2'b11);
        chk("t1_addr0", bank_addr[0], 32'h10);
        chk("t1_addr1", bank_addr[1], 32'h14);
        chk("t1_gnt", gnt, 1);
        tick(); req = 1'b0; bank_gnt = 2'b11;
        #1 chk("t1_req_held", bank_req, 2'b11);
        tick();
        chk("t1_req_drained", bank_req, 2'b00);
        chk("t1_outstanding", outstanding, 1);
        chk("t1_busy", busy, 1);
        bank_rvalid = 2'b01; bank_rdata[0] = 32'h11111111; bank_ruser = 2'b00;
        tick(); bank_rvalid = 2'b00;
        #1 chk("t1_no_early_rvalid", rvalid, 0);
        bank_rvalid = 2'b10; bank_rdata[1] = 32'h22222222; bank_ruser[1] = 1'b1;
        tick(); bank_rvalid = 2'b00;
        #1;
        chk("t1_rvalid", rvalid, 1);
        chk("t1_rdata", rdata, 64'h22222222_11111111);
        chk("t1_ruser", ruser, 2'b10);
        tick();
        chk("t1_rvalid_done", rvalid, 0);
        chk("t1_out_done", outstanding, 0);

        // Test 2: write, lower lane only
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 64'hAAAAAAAA_55555555; strb = 8'h0F; wuser = 1'b1;
        #1;
        chk("t2_bank_req", bank_req, 2'b01);
        chk("t2_addr0", bank_addr[0], 32'h20);
        chk("t2_wdata0", bank_wdata[0], 32'h55555555);
        chk("t2_strb0", bank_strb[0], 4'hF);
        chk("t2_we0", bank_we[0], 1);
        chk("t2_wuser0", bank_wuser[0], 1);
        tick(); req = 1'b0;
        #1;
        chk("t2_req_drained", bank_req, 2'b00);
        chk("t2_outstanding", outstanding, 1);
        bank_rvalid = 2'b01; bank_rdata[0] = 32'h33333333; bank_rdata[1] = 32'hDEADBEEF; bank_ruser = 2'b11;
        tick(); bank_rvalid = 2'b00;
        #1;
        chk("t2_rvalid", rvalid, 1);
        chk("t2_rdata", rdata, 64'h00000000_33333333);
        chk("t2_ruser", ruser, 2'b01);
        tick();
        chk("t2_out_done", outstanding, 0);

        // Test 3: write with empty strobe
        req = 1'b1; we = 1'b1; addr = 32'h40; strb = 8'h00;
        #1;
        chk("t3_bank_req", bank_req, 2'b00);
        chk("t3_gnt", gnt, 1);
        chk("t3_rvalid_same_cycle", rvalid, 0);
        tick(); req = 1'b0;
        #1;
        chk("t3_rvalid", rvalid, 1);
        chk("t3_outstanding", outstanding, 1);
        chk("t3_rdata", rdata, 64'h0);
        tick();
        chk("t3_rvalid_done", rvalid, 0);
        chk("t3_out_done", outstanding, 0);

        // Test 4: outstanding limit
        req = 1'b1; we = 1'b0; addr = 32'h0; strb = 8'h00;
        tick(); addr = 32'h8;
        #1 chk("t4_gnt_b", gnt, 1);
        tick(); addr = 32'h10;
        #1;
        chk("t4_out_full", outstanding, 2);
        chk("t4_third_blocked", gnt, 0);
        tick();
        chk("t4_still_blocked", gnt, 0);
        chk("t4_no_bank_req", bank_req, 2'b00);
        bank_rvalid = 2'b11; bank_rdata = {32'hA1, 32'hA0}; bank_ruser = 2'b00;
        tick(); bank_rvalid = 2'b00;
        #1;
        chk("t4_rvalid_a", rvalid, 1);
        chk("t4_rdata_a", rdata, 64'h000000A1_000000A0);
        chk("t4_gnt_at_limit", gnt, 0);
        tick();
        chk("t4_out_after_a", outstanding, 1);
        chk("t4_gnt_reopen", gnt, 1);
        tick(); req = 1'b0;
        #1 chk("t4_out_stays_2", outstanding, 2);
        bank_rvalid = 2'b11; bank_rdata = {32'hB1, 32'hB0};
        tick(); bank_rvalid = 2'b00;
        #1 chk("t4_rdata_b", rdata, 64'h000000B1_000000B0);
        tick();
        bank_rvalid = 2'b11; bank_rdata = {32'hC1, 32'hC0};
        tick(); bank_rvalid = 2'b00; req = 1'b1; addr = 32'h18;
        #1;
        chk("t4_rvalid_c", rvalid, 1);
        chk("t4_gnt_with_rvalid", gnt, 1);
        chk("t4_rdata_c", rdata, 64'h000000C1_000000C0);
        tick(); req = 1'b0;
        #1 chk("t4_simul_inc_dec", outstanding, 1);
        bank_rvalid = 2'b11; bank_rdata = {32'hD1, 32'hD0};
        tick(); bank_rvalid = 2'b00;
        #1 chk("t4_rdata_d", rdata, 64'h000000D1_000000D0);
        tick();
        chk("t4_out_done", outstanding, 0);

        // Test 5: lane 1 stalled, lane 0 keeps draining
        bank_gnt = 2'b01; req = 1'b1; we = 1'b0; addr = 32'h100; strb = 8'h00;
        #1 chk("t5_req_both", bank_req, 2'b11);
        tick(); we = 1'b1; addr = 32'h200; wdata = 64'h00000000_CAFEF00D; strb = 8'h0F;
        #1;
        chk("t5_gnt_lane0_only", gnt, 1);
        chk("t5_addr0_b", bank_addr[0], 32'h200);
        tick(); req = 1'b0;
        #1;
        chk("t5_lane1_waiting", bank_req, 2'b10);
        chk("t5_out", outstanding, 2);
        bank_rvalid = 2'b01; bank_rdata[0] = 32'h0A0A0A0A;
        tick(); bank_rdata[0] = 32'h0B0B0B0B;
        tick(); bank_rvalid = 2'b00;
        #1 chk("t5_no_rvalid", rvalid, 0);
        tick();
        chk("t5_addr1_held", bank_addr[1], 32'h104);
        bank_gnt = 2'b11;
        tick();
        chk("t5_lane1_drained", bank_req, 2'b00);
        bank_rvalid = 2'b10; bank_rdata[1] = 32'h1A1A1A1A;
        tick(); bank_rvalid = 2'b00;
        #1;
        chk("t5_rvalid_a", rvalid, 1);
        chk("t5_rdata_a", rdata, 64'h1A1A1A1A_0A0A0A0A);
        tick();
        chk("t5_rvalid_b", rvalid, 1);
        chk("t5_rdata_b", rdata, 64'h00000000_0B0B0B0B);
        tick();
        chk("t5_rvalid_done", rvalid, 0);
        chk("t5_out_done", outstanding, 0);

        // Test 6: reset with two transactions in flight
        bank_gnt = 2'b11; req = 1'b1; we = 1'b0; addr = 32'h0; strb = 8'h00;
        tick(); tick(); req = 1'b0;
        #1 chk("t6_out_before", outstanding, 2);
        bank_rvalid = 2'b11; bank_rdata = {32'hE1, 32'hE0};
        tick(); bank_rvalid = 2'b00;
        #1 chk("t6_rvalid_before", rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_out_reset", outstanding, 0);
        chk("t6_rvalid_reset", rvalid, 0);
        chk("t6_busy_reset", busy, 0);
        chk("t6_bank_req_reset", bank_req, 2'b00);
        #2 rst_n = 1'b1;
        tick();
        chk("t6_gnt_after", gnt, 1);
        chk("t6_out_after", outstanding, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
